// File: rtl/fifo_pkg.sv
// Shared types and pointer-code helpers for the asynchronous FIFO read domain.
package fifo_pkg;

  localparam int ADDRSIZE  = 4;
  localparam int PTR_MAX_W = 16;

  typedef logic [ADDRSIZE:0]    ptr_t;
  typedef logic [PTR_MAX_W-1:0] wide_ptr_t;

  typedef enum logic {ARB, BURST} state_e;

  // The helpers work on zero-extended pointers, so they serve any width up to PTR_MAX_W.
  function automatic wide_ptr_t bin2gray(input wide_ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic wide_ptr_t gray2bin(input wide_ptr_t g);
    wide_ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Read-port bundle between the FIFO read controller (slave) and its consumers/synchronizer (master).
interface fifo_rd_arbiter_if #(
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [ADDRSIZE:0]   rq2_wptr;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                rvalid;
  logic [IDW-1:0]      rid;

  modport slave (
    input  rq2_wptr, req,
    output gnt, raddr, rptr, rempty, rlevel, rvalid, rid
  );

  modport master (
    output rq2_wptr, req,
    input  gnt, raddr, rptr, rempty, rlevel, rvalid, rid
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after index last_i, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int k;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    k      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last_i) + i) % NREQ;
      if (!any_o && req_i[k]) begin
        any_o     = 1'b1;
        idx_o     = IDW'(k);
        pick_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// FIFO read-domain controller: round-robin burst arbitration of the single read port,
// read pointer (binary/Gray), empty flag, fill level and the one-cycle read pipeline.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic              rclk,
  input  logic              rrst_n,
  fifo_rd_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = ADDRSIZE + 1;
  localparam int CW  = $clog2(MAXBURST + 1);

  logic [PW-1:0]   rbin_q, rptr_q, rlevel_q;
  logic            rempty_q, rvalid_q;
  logic [IDW-1:0]  rid_q;
  state_e          state_q;
  logic [IDW-1:0]  owner_q, last_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] pick, gnt;
  logic [IDW-1:0]  pick_idx, gnt_idx;
  logic            pick_any, burst_go, arb_go, rinc;
  logic [PW-1:0]   rbin_d, rgray_d, wbin;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // A burst that cannot continue falls through to arbitration in the same cycle,
  // with the departing owner at lowest priority because last_q already points at it.
  assign burst_go = (state_q == BURST) && bus.req[owner_q] && !rempty_q
                    && (cnt_q < CW'(MAXBURST));
  assign arb_go   = !burst_go && !rempty_q && pick_any;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (burst_go) begin
      gnt[owner_q] = 1'b1;
      gnt_idx      = owner_q;
    end else if (arb_go) begin
      gnt     = pick;
      gnt_idx = pick_idx;
    end
  end

  assign rinc    = |gnt;
  assign rbin_d  = rbin_q + PW'(rinc);
  assign rgray_d = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
  assign wbin    = PW'(gray2bin(PTR_MAX_W'(bus.rq2_wptr)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= (rgray_d == bus.rq2_wptr);
      rlevel_q <= wbin - rbin_d;
      rvalid_q <= rinc;
      rid_q    <= gnt_idx;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= ARB;
      owner_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else if (burst_go) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (arb_go) begin
      owner_q <= pick_idx;
      last_q  <= pick_idx;
      cnt_q   <= CW'(1);
      state_q <= (MAXBURST > 1) ? BURST : ARB;
    end else begin
      state_q <= ARB;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.raddr  = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;
  assign bus.rlevel = rlevel_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rid    = rid_q;

endmodule
